// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the flash read path: arbiter FSM state
//               encoding, client index constants, default timing values and
//               a byte-lane select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Client indices double as bit positions in the two-bit request vector.
    localparam logic CLIENT_PRG = 1'b0;
    localparam logic CLIENT_CHR = 1'b1;

    localparam int DEF_WAIT_CYCLES = 4;
    localparam int DEF_RST_CYCLES  = 16;

    // Lane 0 is the low byte of the 16-bit flash word, lane 1 the high byte.
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic lane);
        return lane ? word[15:8] : word[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. When both requests are
//               pending the client not granted last wins; a single pending
//               request always wins. The last-grant pointer only moves when
//               i_update is high, so a grant offer can be made every cycle
//               while the owner decides when it is actually taken.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_req[1:0]      - requests, indexed by client index
//               i_update        - commit the offered grant to the pointer
//               o_valid         - at least one request pending
//               o_gnt_idx       - client index of the offered grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_gnt_idx
);

    logic r_last;
    logic w_both;

    assign w_both    = i_req[CLIENT_PRG] & i_req[CLIENT_CHR];
    assign o_valid   = |i_req;
    assign o_gnt_idx = w_both ? ~r_last
                              : (i_req[CLIENT_CHR] ? CLIENT_CHR : CLIENT_PRG);

    // Pointer starts at PRG so the first contested grant after reset is CHR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= CLIENT_PRG;
        end else if (i_update && o_valid) begin
            r_last <= o_gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_read_arbiter
// Description : Arbitrates PRG and CHR byte-read clients onto the shared
//               16-bit NOR flash bus, runs a fixed-wait asynchronous word
//               read and returns the selected byte with a one-cycle ack.
//               Also holds flash_reset_n low for RST_CYCLES after reset.
// Options     : LAST_WORD_CACHE_EN - keep the last captured word plus its
//               word-address tag; a request hitting it is acked the next
//               cycle without touching the bus.
// Ports       : clk, rst                 - memory clock, sync active-high reset
//               ready                    - flash reset sequence complete
//               prg_req/addr/ack/data    - PRG byte client
//               chr_req/addr/ack/data    - CHR byte client
//               shared_a, shared_d_in    - flash word address / read data
//               shared_oe_n, shared_we_n - output / write enable (we_n tied 1)
//               flash_ce_n, flash_reset_n- chip enable / flash reset
// Revision    : 1.0 - initial release
// ============================================================================
module flash_read_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              prg_req,
    input  logic [ADDR_W:0]   prg_addr,
    output logic              prg_ack,
    output logic [7:0]        prg_data,
    input  logic              chr_req,
    input  logic [ADDR_W:0]   chr_addr,
    output logic              chr_ack,
    output logic [7:0]        chr_data,
    output logic [ADDR_W-1:0] shared_a,
    input  logic [15:0]       shared_d_in,
    output logic              shared_oe_n,
    output logic              shared_we_n,
    output logic              flash_ce_n,
    output logic              flash_reset_n
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int WCW = $clog2(WAIT_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

    state_t            r_state,    w_state_nxt;
    logic [RCW-1:0]    r_rcnt,     w_rcnt_nxt;
    logic [WCW-1:0]    r_wcnt,     w_wcnt_nxt;
    logic              r_ready,    w_ready_nxt;
    logic              r_frst_n,   w_frst_n_nxt;
    logic              r_ce_n,     w_ce_n_nxt;
    logic              r_oe_n,     w_oe_n_nxt;
    logic [ADDR_W-1:0] r_a,        w_a_nxt;
    logic              r_lane,     w_lane_nxt;
    logic              r_gnt,      w_gnt_nxt;
    logic              r_prg_ack,  w_prg_ack_nxt;
    logic              r_chr_ack,  w_chr_ack_nxt;
    logic [7:0]        r_prg_data, w_prg_data_nxt;
    logic [7:0]        r_chr_data, w_chr_data_nxt;

    logic [1:0]        w_req;
    logic              w_arb_valid;
    logic              w_arb_idx;
    logic              w_arb_upd;
    logic [ADDR_W:0]   w_sel_addr;
    logic [ADDR_W-1:0] w_sel_word;
    logic              w_sel_lane;
    logic [7:0]        w_bus_byte;
    logic              w_hit;
    logic [7:0]        w_hit_byte;

    assign w_req[CLIENT_PRG] = prg_req;
    assign w_req[CLIENT_CHR] = chr_req;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_req),
        .i_update (w_arb_upd),
        .o_valid  (w_arb_valid),
        .o_gnt_idx(w_arb_idx)
    );

    assign w_sel_addr = (w_arb_idx == CLIENT_CHR) ? chr_addr : prg_addr;
    assign w_sel_word = w_sel_addr[ADDR_W:1];
    assign w_sel_lane = w_sel_addr[0];
    assign w_bus_byte = pick_byte(shared_d_in, r_lane);

`ifdef LAST_WORD_CACHE_EN
    logic [15:0]       r_cword;
    logic [ADDR_W-1:0] r_ctag;
    logic              r_cvalid;

    assign w_hit      = r_cvalid && (r_ctag == w_sel_word);
    assign w_hit_byte = pick_byte(r_cword, w_sel_lane);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cword  <= 16'h0000;
            r_ctag   <= '0;
            r_cvalid <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_cword  <= shared_d_in;
            r_ctag   <= r_a;
            r_cvalid <= 1'b1;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_byte = 8'h00;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_rcnt_nxt     = r_rcnt;
        w_wcnt_nxt     = r_wcnt;
        w_ready_nxt    = r_ready;
        w_frst_n_nxt   = r_frst_n;
        w_ce_n_nxt     = r_ce_n;
        w_oe_n_nxt     = r_oe_n;
        w_a_nxt        = r_a;
        w_lane_nxt     = r_lane;
        w_gnt_nxt      = r_gnt;
        w_prg_ack_nxt  = 1'b0;
        w_chr_ack_nxt  = 1'b0;
        w_prg_data_nxt = r_prg_data;
        w_chr_data_nxt = r_chr_data;
        w_arb_upd      = 1'b0;

        case (r_state)
            ST_RESET: begin
                if (r_rcnt == RST_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_ready_nxt  = 1'b1;
                    w_frst_n_nxt = 1'b1;
                end else begin
                    w_rcnt_nxt = r_rcnt + RCW'(1);
                end
            end

            ST_IDLE: begin
                // No grant while an ack is showing: the acked client still
                // holds req this cycle, and this also guarantees a ce_n=1
                // turnaround cycle between back-to-back accesses.
                if (w_arb_valid && !r_prg_ack && !r_chr_ack) begin
                    w_arb_upd = 1'b1;
                    if (w_hit) begin
                        if (w_arb_idx == CLIENT_CHR) begin
                            w_chr_ack_nxt  = 1'b1;
                            w_chr_data_nxt = w_hit_byte;
                        end else begin
                            w_prg_ack_nxt  = 1'b1;
                            w_prg_data_nxt = w_hit_byte;
                        end
                    end else begin
                        w_a_nxt     = w_sel_word;
                        w_lane_nxt  = w_sel_lane;
                        w_gnt_nxt   = w_arb_idx;
                        w_ce_n_nxt  = 1'b0;
                        w_oe_n_nxt  = 1'b0;
                        w_wcnt_nxt  = '0;
                        w_state_nxt = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (r_wcnt == WAIT_LAST) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_wcnt_nxt = r_wcnt + WCW'(1);
                end
            end

            ST_CAPTURE: begin
                w_ce_n_nxt  = 1'b1;
                w_oe_n_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
                if (r_gnt == CLIENT_CHR) begin
                    w_chr_ack_nxt  = 1'b1;
                    w_chr_data_nxt = w_bus_byte;
                end else begin
                    w_prg_ack_nxt  = 1'b1;
                    w_prg_data_nxt = w_bus_byte;
                end
            end

            default: w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RESET;
            r_rcnt     <= '0;
            r_wcnt     <= '0;
            r_ready    <= 1'b0;
            r_frst_n   <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_a        <= '0;
            r_lane     <= 1'b0;
            r_gnt      <= CLIENT_PRG;
            r_prg_ack  <= 1'b0;
            r_chr_ack  <= 1'b0;
            r_prg_data <= 8'h00;
            r_chr_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_ready    <= w_ready_nxt;
            r_frst_n   <= w_frst_n_nxt;
            r_ce_n     <= w_ce_n_nxt;
            r_oe_n     <= w_oe_n_nxt;
            r_a        <= w_a_nxt;
            r_lane     <= w_lane_nxt;
            r_gnt      <= w_gnt_nxt;
            r_prg_ack  <= w_prg_ack_nxt;
            r_chr_ack  <= w_chr_ack_nxt;
            r_prg_data <= w_prg_data_nxt;
            r_chr_data <= w_chr_data_nxt;
        end
    end

    assign ready         = r_ready;
    assign flash_reset_n = r_frst_n;
    assign flash_ce_n    = r_ce_n;
    assign shared_oe_n   = r_oe_n;
    assign shared_we_n   = 1'b1;
    assign shared_a      = r_a;
    assign prg_ack       = r_prg_ack;
    assign chr_ack       = r_chr_ack;
    assign prg_data      = r_prg_data;
    assign chr_data      = r_chr_data;

endmodule
`default_nettype wire

// File: tb/tb_flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_read_arbiter
// Description : Self-checking bench for flash_read_arbiter. A timestamp-based
//               transaction model predicts every output each cycle; directed
//               reads add hand-computed latency / data expectations.
//               Honours LAST_WORD_CACHE_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_read_arbiter;

    localparam int AW    = 23;
    localparam int WAITC = 4;
    localparam int RSTC  = 16;
`ifdef LAST_WORD_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prg_req = 1'b0;
    logic          chr_req = 1'b0;
    logic [AW:0]   prg_addr = '0;
    logic [AW:0]   chr_addr = '0;
    logic          ready, prg_ack, chr_ack;
    logic [7:0]    prg_data, chr_data;
    logic [AW-1:0] shared_a;
    logic [15:0]   shared_d_in;
    logic          shared_oe_n, shared_we_n, flash_ce_n, flash_reset_n;

    int n_checks = 0;
    int n_fail   = 0;

    flash_read_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WAITC), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .prg_req(prg_req), .prg_addr(prg_addr), .prg_ack(prg_ack), .prg_data(prg_data),
        .chr_req(chr_req), .chr_addr(chr_addr), .chr_ack(chr_ack), .chr_data(chr_data),
        .shared_a(shared_a), .shared_d_in(shared_d_in), .shared_oe_n(shared_oe_n),
        .shared_we_n(shared_we_n), .flash_ce_n(flash_ce_n), .flash_reset_n(flash_reset_n)
    );

    always #10 clk = ~clk;

    // Flash contents: two fixed words plus an address-derived pattern.
    function automatic logic [15:0] flash_word(input logic [AW-1:0] w);
        case (w)
            23'd2:   return 16'hA55A;
            23'd8:   return 16'h1234;
            default: return {w[7:0] ^ 8'hC3, w[7:0] ^ 8'h3C};
        endcase
    endfunction

    // Flash only drives valid data once oe_n has been low WAITC cycles.
    int oe_low_cnt = 0;
    always @(posedge clk) oe_low_cnt <= shared_oe_n ? 0 : oe_low_cnt + 1;
    assign shared_d_in = (!flash_ce_n && !shared_oe_n && oe_low_cnt >= WAITC)
                         ? flash_word(shared_a) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    int            n = 0;
    int            rst_edge = 0;
    int            grant_edge = 0;
    bit            busy = 1'b0;
    logic          m_last = 1'b0;      // 0 = PRG, 1 = CHR
    logic          m_cli = 1'b0;
    logic [AW:0]   m_baddr = '0;
    logic          e_ready = 1'b0, e_frst = 1'b0, e_ce = 1'b1, e_oe = 1'b1;
    logic          e_pack = 1'b0, e_cack = 1'b0;
    logic [7:0]    e_pdata = 8'h00, e_cdata = 8'h00;
    logic [AW-1:0] e_a = '0;
    bit            mc_valid = 1'b0;
    logic [AW-1:0] mc_tag = '0;
    logic [15:0]   mc_word = 16'h0;
    logic          m_blocked;
    logic [15:0]   m_word;
    logic [7:0]    m_byte;

    initial forever begin
        @(posedge clk);
        n++;
        if (rst) begin
            rst_edge = n;
            e_ready = 1'b0; e_frst = 1'b0; e_ce = 1'b1; e_oe = 1'b1; e_a = '0;
            e_pack = 1'b0; e_cack = 1'b0; e_pdata = 8'h00; e_cdata = 8'h00;
            m_last = 1'b0; busy = 1'b0; mc_valid = 1'b0;
        end else begin
            m_blocked = e_pack | e_cack;
            e_pack = 1'b0; e_cack = 1'b0;
            if (!e_ready) begin
                if (n - rst_edge == RSTC) begin
                    e_ready = 1'b1; e_frst = 1'b1;
                end
            end else if (busy) begin
                if (n - grant_edge == WAITC + 1) begin
                    m_word = flash_word(m_baddr[AW:1]);
                    m_byte = m_baddr[0] ? m_word[15:8] : m_word[7:0];
                    if (m_cli) begin e_cack = 1'b1; e_cdata = m_byte; end
                    else       begin e_pack = 1'b1; e_pdata = m_byte; end
                    e_ce = 1'b1; e_oe = 1'b1; busy = 1'b0;
                    mc_valid = 1'b1; mc_tag = m_baddr[AW:1]; mc_word = m_word;
                end
            end else if (!m_blocked && (prg_req || chr_req)) begin
                m_cli   = (prg_req && chr_req) ? ~m_last : chr_req;
                m_last  = m_cli;
                m_baddr = m_cli ? chr_addr : prg_addr;
                if (CACHE_ON && mc_valid && mc_tag == m_baddr[AW:1]) begin
                    m_byte = m_baddr[0] ? mc_word[15:8] : mc_word[7:0];
                    if (m_cli) begin e_cack = 1'b1; e_cdata = m_byte; end
                    else       begin e_pack = 1'b1; e_pdata = m_byte; end
                end else begin
                    busy = 1'b1; grant_edge = n;
                    e_a = m_baddr[AW:1]; e_ce = 1'b0; e_oe = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (n > 0) begin
            chk("ready",         32'(ready),         32'(e_ready));
            chk("flash_reset_n", 32'(flash_reset_n), 32'(e_frst));
            chk("flash_ce_n",    32'(flash_ce_n),    32'(e_ce));
            chk("shared_oe_n",   32'(shared_oe_n),   32'(e_oe));
            chk("shared_we_n",   32'(shared_we_n),   32'd1);
            chk("prg_ack",       32'(prg_ack),       32'(e_pack));
            chk("chr_ack",       32'(chr_ack),       32'(e_cack));
            chk("prg_data",      32'(prg_data),      32'(e_pdata));
            chk("chr_data",      32'(chr_data),      32'(e_cdata));
            if (!e_ce) chk("shared_a", 32'(shared_a), 32'(e_a));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ready(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (flash_reset_n) begin k = i; break; end
        end
    endtask

    task automatic do_read(input logic is_chr, input logic [AW:0] addr, input logic disturb,
                           output int lat, output int oe_cnt, output logic [7:0] data,
                           output logic [AW-1:0] a_grant);
        lat = 0; oe_cnt = 0; data = 8'h00; a_grant = '0;
        repeat (2) begin @(posedge clk); #1; end
        if (is_chr) begin chr_addr = addr; chr_req = 1'b1; end
        else        begin prg_addr = addr; prg_req = 1'b1; end
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                a_grant = shared_a;
                if (disturb) begin
                    // Address change and early req drop after grant.
                    if (is_chr) begin chr_addr = 24'h000100; chr_req = 1'b0; end
                    else        begin prg_addr = 24'h000100; prg_req = 1'b0; end
                end
            end
            if (!shared_oe_n) oe_cnt++;
            if (is_chr ? chr_ack : prg_ack) begin
                lat = k;
                data = is_chr ? chr_data : prg_data;
                break;
            end
        end
        chr_req = 1'b0; prg_req = 1'b0;
    endtask

    int            k_rel, lat, oe_cnt;
    logic [7:0]    data;
    logic [AW-1:0] a_grant;
    int            seq[$];
    int            exp_order[4] = '{1, 0, 1, 0};

    initial begin
        // Reset state and release timing.
        @(posedge clk); #1;
        chk("rst_ready",    32'(ready),         32'd0);
        chk("rst_frst_n",   32'(flash_reset_n), 32'd0);
        chk("rst_ce_n",     32'(flash_ce_n),    32'd1);
        chk("rst_oe_n",     32'(shared_oe_n),   32'd1);
        chk("rst_shared_a", 32'(shared_a),      32'd0);
        chk("rst_data",     32'({prg_data, chr_data}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready(k_rel);
        chk("reset_release_cycles", k_rel, 16);
        chk("ready_with_frst", 32'(ready), 32'd1);

        // PRG byte 5 -> word 2 (A55A), high lane.
        do_read(1'b0, 24'h000005, 1'b0, lat, oe_cnt, data, a_grant);
        chk("prg_read_shared_a", 32'(a_grant), 32'h2);
        chk("prg_read_oe_low",   oe_cnt, 5);
        chk("prg_read_latency",  lat, 6);
        chk("prg_read_data",     32'(data), 32'hA5);

        // Address change + req drop after grant: byte 7 -> word 3 = C03F, lane 1.
        do_read(1'b0, 24'h000007, 1'b1, lat, oe_cnt, data, a_grant);
        chk("disturb_latency", lat, 6);
        chk("disturb_data",    32'(data), 32'hC0);

        // Reset during ACCESS of a CHR read.
        repeat (2) begin @(posedge clk); #1; end
        chr_addr = 24'h000030; chr_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("access_oe_low", 32'(shared_oe_n), 32'd0);
        rst = 1'b1; chr_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ce_n",    32'(flash_ce_n),    32'd1);
        chk("midrst_oe_n",    32'(shared_oe_n),   32'd1);
        chk("midrst_ready",   32'(ready),         32'd0);
        chk("midrst_frst_n",  32'(flash_reset_n), 32'd0);
        chk("midrst_chr_ack", 32'(chr_ack),       32'd0);
        rst = 1'b0;
        wait_ready(k_rel);
        chk("re_reset_release_cycles", k_rel, 16);

        // Both held after reset: CHR, PRG, CHR, PRG.
        repeat (2) begin @(posedge clk); #1; end
        chr_addr = 24'h000020; prg_addr = 24'h000041;
        chr_req = 1'b1; prg_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (prg_ack) seq.push_back(0);
            if (chr_ack) seq.push_back(1);
            if (seq.size() >= 4) break;
        end
        chr_req = 1'b0; prg_req = 1'b0;
        chk("rr_ack_count", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++)
            chk($sformatf("rr_order_%0d", i), seq[i], exp_order[i]);

        // Same word, two lanes: word 8 = 1234.
        do_read(1'b1, 24'h000010, 1'b0, lat, oe_cnt, data, a_grant);
        chk("chr_lo_latency", lat, 6);
        chk("chr_lo_data",    32'(data), 32'h34);
        do_read(1'b1, 24'h000011, 1'b0, lat, oe_cnt, data, a_grant);
        chk("chr_hi_data",    32'(data), 32'h12);
`ifdef LAST_WORD_CACHE_EN
        chk("chr_hi_latency", lat, 1);
        chk("chr_hi_oe_low",  oe_cnt, 0);
`else
        chk("chr_hi_latency", lat, 6);
        chk("chr_hi_oe_low",  oe_cnt, 5);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
